// File: rtl/mobo_mem_port_pkg.sv
// Shared definitions for the motherboard memory port: word width, cpu command
// codes, status bit positions and the port FSM state encoding. The cpu's
// request FSM imports the same package so both sides agree on the encodings.
package mobo_mem_port_pkg;

    localparam int WORD_WIDTH = 32;

    // Command codes carried in mobo_ctrl[1:0]
    localparam logic [1:0] MOBO_CMD_IDLE  = 2'd0;
    localparam logic [1:0] MOBO_CMD_READ  = 2'd1;
    localparam logic [1:0] MOBO_CMD_WRITE = 2'd2;
    localparam logic [1:0] MOBO_CMD_RSVD  = 2'd3;

    // Bit positions inside mobo_stat
    localparam int MOBO_STAT_BUSY = 0;
    localparam int MOBO_STAT_DONE = 1;
    localparam int MOBO_STAT_ERR  = 2;

    typedef enum logic [1:0] {
        PORT_IDLE   = 2'd0,
        PORT_WAIT   = 2'd1,
        PORT_ACCESS = 2'd2,
        PORT_DONE   = 2'd3
    } port_state_e;

    // Assemble a status word; all bits above ERR stay zero.
    function automatic logic [WORD_WIDTH-1:0] mobo_stat_word(
        input logic busy,
        input logic done,
        input logic err
    );
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[MOBO_STAT_BUSY] = busy;
        w[MOBO_STAT_DONE] = done;
        w[MOBO_STAT_ERR]  = err;
        return w;
    endfunction

endpackage

// File: rtl/mobo_mem_port_if.sv
// Bus between the cpu and the motherboard memory port.
// Handshake is 4-phase: the cpu (master) drives a non-zero command and holds
// it; the port (slave) shows BUSY, then DONE (with ERR on a rejected command);
// the cpu returns the command to 0 and the port clears its status and goes
// idle. dbg_state mirrors the port FSM state for observation only.
interface mobo_mem_port_if
    import mobo_mem_port_pkg::*;
();
    logic [WORD_WIDTH-1:0] mobo_ctrl;
    logic [WORD_WIDTH-1:0] mobo_stat;
    logic [WORD_WIDTH-1:0] addr_in;
    logic [WORD_WIDTH-1:0] wdata_in;
    logic [WORD_WIDTH-1:0] rdata_out;
    port_state_e           dbg_state;

    modport master (
        output mobo_ctrl, addr_in, wdata_in,
        input  mobo_stat, rdata_out, dbg_state
    );

    modport slave (
        input  mobo_ctrl, addr_in, wdata_in,
        output mobo_stat, rdata_out, dbg_state
    );
endinterface

// File: rtl/mobo_ram.sv
// Single-port synchronous RAM with a registered, one-cycle read.
// Reads are read-first: a write in the same cycle returns the old word.
module mobo_ram #(
    parameter int WORD_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);
    logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];

    // Storage write and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mobo_mem_port.sv
// Motherboard-side memory port. Accepts READ/WRITE commands from the cpu,
// inserts WAIT_CYCLES wait states, performs the access on mobo_ram and
// reports completion through mobo_stat / rdata_out.
// The status/data outputs form a register stage one edge behind the FSM, so
// BUSY appears one edge after a command is sampled and DONE appears
// WAIT_CYCLES+2 edges after it (one edge after for a rejected command).
module mobo_mem_port
    import mobo_mem_port_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    mobo_mem_port_if.slave   bus
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    localparam logic [CW-1:0]         WAIT_INIT = CW'(WAIT_CYCLES);
    localparam logic [WORD_WIDTH-1:0] DEPTH_W   = WORD_WIDTH'(MEM_DEPTH);

    port_state_e           state;
    logic [1:0]            cmd;
    logic [1:0]            op_q;
    logic [AW-1:0]         addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic                  fresh_q;   // first cycle spent in DONE
    logic [CW-1:0]         wait_cnt;
    logic [WORD_WIDTH-1:0] stat_q;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  ram_we;
    logic [WORD_WIDTH-1:0] ram_rdata;
    logic                  unused_ctrl_bits;

    assign cmd              = bus.mobo_ctrl[1:0];
    assign unused_ctrl_bits = ^bus.mobo_ctrl[WORD_WIDTH-1:2];

    // Port FSM: latch the request in IDLE, count wait states, access, then
    // hold DONE until the cpu returns its command to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PORT_IDLE;
            op_q     <= MOBO_CMD_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            fresh_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            fresh_q <= 1'b0;
            case (state)
                PORT_IDLE: begin
                    if (cmd == MOBO_CMD_READ || cmd == MOBO_CMD_WRITE) begin
                        op_q    <= cmd;
                        addr_q  <= bus.addr_in[AW-1:0];
                        wdata_q <= bus.wdata_in;
                        if (bus.addr_in >= DEPTH_W) begin
                            err_q   <= 1'b1;
                            fresh_q <= 1'b1;
                            state   <= PORT_DONE;
                        end else begin
                            err_q    <= 1'b0;
                            wait_cnt <= WAIT_INIT;
                            state    <= (WAIT_CYCLES == 0) ? PORT_ACCESS : PORT_WAIT;
                        end
                    end else if (cmd == MOBO_CMD_RSVD) begin
                        op_q    <= cmd;
                        err_q   <= 1'b1;
                        fresh_q <= 1'b1;
                        state   <= PORT_DONE;
                    end
                end
                PORT_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt <= 1) begin
                        state <= PORT_ACCESS;
                    end
                end
                PORT_ACCESS: begin
                    fresh_q <= 1'b1;
                    state   <= PORT_DONE;
                end
                PORT_DONE: begin
                    if (cmd == MOBO_CMD_IDLE) begin
                        err_q <= 1'b0;
                        state <= PORT_IDLE;
                    end
                end
                default: state <= PORT_IDLE;
            endcase
        end
    end

    // Output stage: status follows the FSM one edge later; read data is taken
    // from the RAM register on the first DONE cycle, zeroed on a rejected read
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q  <= '0;
            rdata_q <= '0;
        end else if (state == PORT_DONE) begin
            if (fresh_q) begin
                stat_q <= mobo_stat_word(1'b0, 1'b1, err_q);
                if (op_q == MOBO_CMD_READ) begin
                    rdata_q <= err_q ? '0 : ram_rdata;
                end
            end else if (cmd == MOBO_CMD_IDLE) begin
                stat_q <= '0;
            end
        end else begin
            stat_q <= mobo_stat_word(state == PORT_WAIT || state == PORT_ACCESS, 1'b0, 1'b0);
        end
    end

    // A reset landing on the access edge must still suppress the write
    assign ram_we = (state == PORT_ACCESS) && (op_q == MOBO_CMD_WRITE) && !rst;

    mobo_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.mobo_stat = stat_q;
    assign bus.rdata_out = rdata_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_mobo_mem_port.sv
// Directed bench for mobo_mem_port: instance A uses WAIT_CYCLES=2, instance B
// uses WAIT_CYCLES=0. Ticks are counted from the command being driven: the
// first tick is the edge that samples it, so DONE for a normal access shows
// after WAIT_CYCLES+3 ticks and a rejected command after 2 ticks.
module tb_mobo_mem_port;
    import mobo_mem_port_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mobo_mem_port_if bus_a ();
    mobo_mem_port_if bus_b ();

    mobo_mem_port #(.MEM_DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mobo_mem_port #(.MEM_DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel_b, input logic [1:0] cmd,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel_b) begin
            bus_b.mobo_ctrl = {30'd0, cmd};
            bus_b.addr_in   = addr;
            bus_b.wdata_in  = data;
        end else begin
            bus_a.mobo_ctrl = {30'd0, cmd};
            bus_a.addr_in   = addr;
            bus_a.wdata_in  = data;
        end
    endtask

    // Full 4-phase transfer: drive, wait (bounded) for DONE, drop cmd, one edge.
    // ticks = -1 if DONE never showed.
    task automatic xfer(input bit sel_b, input logic [1:0] cmd,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int ticks, output logic [31:0] stat,
                        output logic [31:0] rdata);
        logic [31:0] cur;
        bit seen;
        drive(sel_b, cmd, addr, data);
        ticks = -1;
        seen  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                tick();
                cur = sel_b ? bus_b.mobo_stat : bus_a.mobo_stat;
                if (cur[1]) begin
                    seen  = 1'b1;
                    ticks = i;
                end
            end
        end
        stat  = sel_b ? bus_b.mobo_stat : bus_a.mobo_stat;
        rdata = sel_b ? bus_b.rdata_out : bus_a.rdata_out;
        drive(sel_b, MOBO_CMD_IDLE, 32'd0, 32'd0);
        tick();
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus_a.mobo_stat !== 32'h0) begin bad++; $display("FAIL reset_stat_a: got %h want %h", bus_a.mobo_stat, 32'h0); end
        total++; if (bus_a.rdata_out !== 32'h0) begin bad++; $display("FAIL reset_rdata_a: got %h want %h", bus_a.rdata_out, 32'h0); end
        total++; if (bus_a.dbg_state !== PORT_IDLE) begin bad++; $display("FAIL reset_state_a: got %0d want %0d", bus_a.dbg_state, PORT_IDLE); end
        total++; if (bus_b.mobo_stat !== 32'h0) begin bad++; $display("FAIL reset_stat_b: got %h want %h", bus_b.mobo_stat, 32'h0); end
    endtask

    task automatic test_preload();
        int t; logic [31:0] s, r;
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        addrs = '{32'd0, 32'd6, 32'd7, 32'd10};
        datas = '{32'h0000_C0DE, 32'h0000_0066, 32'h0000_0077, 32'h0000_1010};
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, MOBO_CMD_WRITE, addrs[i], datas[i], t, s, r);
            total++; if (t !== 5) begin bad++; $display("FAIL preload_lat[%0d]: got %0d want 5", i, t); end
            total++; if (s !== 32'h2) begin bad++; $display("FAIL preload_stat[%0d]: got %h want %h", i, s, 32'h2); end
        end
    endtask

    task automatic test_write_latency();
        drive(1'b0, MOBO_CMD_WRITE, 32'd5, 32'h0000_00A5);
        tick();
        total++; if (bus_a.mobo_stat !== 32'h0) begin bad++; $display("FAIL wr_e0_stat: got %h want %h", bus_a.mobo_stat, 32'h0); end
        tick();
        total++; if (bus_a.mobo_stat !== 32'h1) begin bad++; $display("FAIL wr_e1_busy: got %h want %h", bus_a.mobo_stat, 32'h1); end
        tick();
        tick();
        total++; if (bus_a.mobo_stat !== 32'h1) begin bad++; $display("FAIL wr_e3_busy: got %h want %h", bus_a.mobo_stat, 32'h1); end
        tick();
        total++; if (bus_a.mobo_stat !== 32'h2) begin bad++; $display("FAIL wr_e4_done: got %h want %h", bus_a.mobo_stat, 32'h2); end
        drive(1'b0, MOBO_CMD_IDLE, 32'd0, 32'd0);
        tick();
        total++; if (bus_a.mobo_stat !== 32'h0) begin bad++; $display("FAIL wr_drop_stat: got %h want %h", bus_a.mobo_stat, 32'h0); end
        total++; if (bus_a.dbg_state !== PORT_IDLE) begin bad++; $display("FAIL wr_drop_state: got %0d want %0d", bus_a.dbg_state, PORT_IDLE); end
    endtask

    task automatic test_read();
        int t; logic [31:0] s, r;
        xfer(1'b0, MOBO_CMD_READ, 32'd5, 32'd0, t, s, r);
        total++; if (t !== 5) begin bad++; $display("FAIL rd5_lat: got %0d want 5", t); end
        total++; if (s !== 32'h2) begin bad++; $display("FAIL rd5_stat: got %h want %h", s, 32'h2); end
        total++; if (r !== 32'h0000_00A5) begin bad++; $display("FAIL rd5_data: got %h want %h", r, 32'h0000_00A5); end
        total++; if (bus_a.rdata_out !== 32'h0000_00A5) begin bad++; $display("FAIL rd5_hold: got %h want %h", bus_a.rdata_out, 32'h0000_00A5); end
        xfer(1'b0, MOBO_CMD_READ, 32'd6, 32'd0, t, s, r);
        total++; if (r !== 32'h0000_0066) begin bad++; $display("FAIL rd6_data: got %h want %h", r, 32'h0000_0066); end
    endtask

    task automatic test_errors();
        int t; logic [31:0] s, r;
        xfer(1'b0, MOBO_CMD_READ, 32'd0, 32'd0, t, s, r);
        total++; if (r !== 32'h0000_C0DE) begin bad++; $display("FAIL rd0_before: got %h want %h", r, 32'h0000_C0DE); end
        xfer(1'b0, MOBO_CMD_READ, 32'd256, 32'd0, t, s, r);
        total++; if (t !== 2) begin bad++; $display("FAIL rd256_lat: got %0d want 2", t); end
        total++; if (s !== 32'h6) begin bad++; $display("FAIL rd256_stat: got %h want %h", s, 32'h6); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rd256_data: got %h want %h", r, 32'h0); end
        total++; if (bus_a.mobo_stat !== 32'h0) begin bad++; $display("FAIL rd256_drop: got %h want %h", bus_a.mobo_stat, 32'h0); end
        xfer(1'b0, MOBO_CMD_RSVD, 32'd0, 32'hDEAD_BEEF, t, s, r);
        total++; if (t !== 2) begin bad++; $display("FAIL cmd3_lat: got %0d want 2", t); end
        total++; if (s !== 32'h6) begin bad++; $display("FAIL cmd3_stat: got %h want %h", s, 32'h6); end
        xfer(1'b0, MOBO_CMD_WRITE, 32'h0100_0000, 32'h0000_BAD0, t, s, r);
        total++; if (s !== 32'h6) begin bad++; $display("FAIL wr_upper_stat: got %h want %h", s, 32'h6); end
        xfer(1'b0, MOBO_CMD_READ, 32'd0, 32'd0, t, s, r);
        total++; if (r !== 32'h0000_C0DE) begin bad++; $display("FAIL rd0_after: got %h want %h", r, 32'h0000_C0DE); end
    endtask

    task automatic test_reset_mid();
        int t; logic [31:0] s, r;
        drive(1'b0, MOBO_CMD_WRITE, 32'd7, 32'h0000_1234);
        tick();
        tick();
        total++; if (bus_a.dbg_state !== PORT_WAIT) begin bad++; $display("FAIL rstmid_in_wait: got %0d want %0d", bus_a.dbg_state, PORT_WAIT); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, MOBO_CMD_IDLE, 32'd0, 32'd0);
        total++; if (bus_a.mobo_stat !== 32'h0) begin bad++; $display("FAIL rstmid_stat: got %h want %h", bus_a.mobo_stat, 32'h0); end
        total++; if (bus_a.rdata_out !== 32'h0) begin bad++; $display("FAIL rstmid_rdata: got %h want %h", bus_a.rdata_out, 32'h0); end
        total++; if (bus_a.dbg_state !== PORT_IDLE) begin bad++; $display("FAIL rstmid_state: got %0d want %0d", bus_a.dbg_state, PORT_IDLE); end
        tick();
        xfer(1'b0, MOBO_CMD_READ, 32'd7, 32'd0, t, s, r);
        total++; if (r !== 32'h0000_0077) begin bad++; $display("FAIL rstmid_rd7: got %h want %h", r, 32'h0000_0077); end
    endtask

    task automatic test_busy_change();
        int t; logic [31:0] s, r;
        int cnt;
        drive(1'b0, MOBO_CMD_WRITE, 32'd9, 32'h0000_9999);
        tick();
        tick();
        total++; if (bus_a.mobo_stat !== 32'h1) begin bad++; $display("FAIL chg_busy: got %h want %h", bus_a.mobo_stat, 32'h1); end
        drive(1'b0, MOBO_CMD_READ, 32'd10, 32'h0000_FFFF);
        cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            if (cnt < 0) begin
                tick();
                if (bus_a.mobo_stat[1]) cnt = i;
            end
        end
        total++; if (cnt !== 3) begin bad++; $display("FAIL chg_lat: got %0d want 3", cnt); end
        total++; if (bus_a.rdata_out !== 32'h0000_0077) begin bad++; $display("FAIL chg_rdata_kept: got %h want %h", bus_a.rdata_out, 32'h0000_0077); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus_a.mobo_stat !== 32'h2) begin bad++; $display("FAIL hold_stat[%0d]: got %h want %h", i, bus_a.mobo_stat, 32'h2); end
            total++; if (bus_a.dbg_state !== PORT_DONE) begin bad++; $display("FAIL hold_state[%0d]: got %0d want %0d", i, bus_a.dbg_state, PORT_DONE); end
        end
        drive(1'b0, MOBO_CMD_IDLE, 32'd0, 32'd0);
        tick();
        total++; if (bus_a.mobo_stat !== 32'h0) begin bad++; $display("FAIL chg_drop: got %h want %h", bus_a.mobo_stat, 32'h0); end
        xfer(1'b0, MOBO_CMD_READ, 32'd9, 32'd0, t, s, r);
        total++; if (r !== 32'h0000_9999) begin bad++; $display("FAIL chg_rd9: got %h want %h", r, 32'h0000_9999); end
        xfer(1'b0, MOBO_CMD_READ, 32'd10, 32'd0, t, s, r);
        total++; if (r !== 32'h0000_1010) begin bad++; $display("FAIL chg_rd10: got %h want %h", r, 32'h0000_1010); end
    endtask

    task automatic test_back_to_back();
        int t; logic [31:0] s, r;
        xfer(1'b1, MOBO_CMD_WRITE, 32'd0, 32'h0000_00B0, t, s, r);
        total++; if (t !== 3) begin bad++; $display("FAIL b_wr0_lat: got %0d want 3", t); end
        total++; if (bus_b.mobo_stat !== 32'h0) begin bad++; $display("FAIL b_wr0_drop: got %h want %h", bus_b.mobo_stat, 32'h0); end
        xfer(1'b1, MOBO_CMD_READ, 32'd0, 32'd0, t, s, r);
        total++; if (t !== 3) begin bad++; $display("FAIL b_rd0_lat: got %0d want 3", t); end
        total++; if (r !== 32'h0000_00B0) begin bad++; $display("FAIL b_rd0_data: got %h want %h", r, 32'h0000_00B0); end
        xfer(1'b1, MOBO_CMD_WRITE, 32'd255, 32'h0000_00B1, t, s, r);
        total++; if (s !== 32'h2) begin bad++; $display("FAIL b_wr255_stat: got %h want %h", s, 32'h2); end
        xfer(1'b1, MOBO_CMD_READ, 32'd255, 32'd0, t, s, r);
        total++; if (r !== 32'h0000_00B1) begin bad++; $display("FAIL b_rd255_data: got %h want %h", r, 32'h0000_00B1); end
    endtask

    // sequence and final report
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, MOBO_CMD_IDLE, 32'd0, 32'd0);
        drive(1'b1, MOBO_CMD_IDLE, 32'd0, 32'd0);
        test_reset();
        test_preload();
        test_write_latency();
        test_read();
        test_errors();
        test_reset_mid();
        test_busy_change();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mobo_mem_port.md
Name: mobo_mem_port

Overview:
- Motherboard-side memory port sitting directly downstream of the cpu.
- Consumes the cpu's mobo_ctrl command word, address register output and outgoing data register output.
- Performs a word read or write on an internal single-port RAM with a programmable wait-state delay.
- Returns completion status on mobo_stat and read data on the cpu's incoming data path (mobodat_in).

Parameters:
word_width, `WORD_WIDTH (32), width of every data/address/ctrl/stat word
MEM_DEPTH, 256, number of RAM words; valid addresses 0..MEM_DEPTH-1
WAIT_CYCLES, 2, extra wait-state cycles inserted before each access (0 allowed)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mobo_ctrl  in  word_width  command from cpu; bits[1:0] = cmd (0 IDLE, 1 READ, 2 WRITE, 3 reserved), upper bits ignored
mobo_stat  out  word_width  status to cpu; bit0 BUSY, bit1 DONE, bit2 ERR, upper bits 0
addr_in  in  word_width  access address (cpu addr_out)
wdata_in  in  word_width  write data (cpu mobodat_out)
rdata_out  out  word_width  read data to cpu (cpu mobodat_in)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high, sampled only on posedge clk.
- Reset: state IDLE, mobo_stat=0, rdata_out=0, wait counter=0. RAM contents are not cleared.
- Reset mid-operation: any pending, not-yet-performed write is aborted; RAM is unchanged.
- All outputs are registered. No combinational path from inputs to outputs.
- Handshake (4-phase):
  - cpu drives cmd≠0 and holds it.
  - Block raises BUSY, later DONE (BUSY=0).
  - cpu returns cmd to 0.
  - Block clears DONE/ERR and returns to IDLE.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE: on an edge with cmd∈{1,2}, latch op, addr_in and wdata_in.
    - If latched addr ≥ MEM_DEPTH: go DONE with DONE=1, ERR=1 after that edge. No RAM access; rdata_out is set to 0 on a read.
    - Otherwise: BUSY=1, counter=WAIT_CYCLES, go WAIT (or ACCESS if WAIT_CYCLES=0).
  - IDLE with cmd=3: go DONE with DONE=1, ERR=1. cmd=0: stay.
  - WAIT: counter decrements each edge; at counter==1 go ACCESS. Inputs are ignored; latched values are used.
  - ACCESS (one cycle): READ updates rdata_out with RAM[addr]; WRITE writes RAM[addr]=wdata. Next state DONE with BUSY=0, DONE=1, ERR=0.
  - DONE: hold DONE/ERR and rdata_out until an edge samples cmd==0; then go IDLE with mobo_stat=0. rdata_out holds its last value.
- Latency: command present before edge E0 → DONE visible after edge E0+WAIT_CYCLES+2. Example: WAIT_CYCLES=2 gives DONE 4 edges after the command is first sampled. Error responses are visible after E0+1.
- BUSY and DONE are never both 1. mobo_stat never carries ERR without DONE.
- Command changes while BUSY are ignored. A new command while DONE and cmd≠0 is not accepted; cmd must pass through 0.
- Address decode uses addr_in[$clog2(MEM_DEPTH)-1:0] after the full-width range check. Upper bits ≠0 means ERR.
- Back-to-back: cmd 0 for one edge in DONE → IDLE; the next command is accepted at the following edge.

Decomposition:
- Shared defines header, alongside the existing mobo state/const headers:
  - command codes MOBO_CMD_IDLE/READ/WRITE
  - stat bit indices MOBO_STAT_BUSY/DONE/ERR
  - port FSM state encoding
- The cpu's request FSM uses the same header.
- One sub-module: mobo_ram.
  - Single-port synchronous RAM: clk, we, addr, wdata, rdata.
  - Registered read, 1-cycle.
  - Parameters word_width, MEM_DEPTH.
- Port FSM, counter and status logic stay in mobo_mem_port.

Test Plan:
- WAIT_CYCLES=2: WRITE addr 5, data 0x0000_00A5 → BUSY=1 after E1, DONE after E4, mobo_stat=0x2. Drop cmd → mobo_stat=0 next edge.
- Then READ addr 5 → rdata_out=0x0000_00A5 with DONE=1 exactly 4 edges after sampling; READ of unwritten addr 6 returns power-up/initialised value unchanged by the write.
- READ addr 256 (MEM_DEPTH=256), and separately cmd=3 → mobo_stat=0x6 after E1, rdata_out=0 for the read; no RAM change (verify addr 0 still holds prior value).
- WRITE addr 7 data 0x1234 with rst asserted 1 cycle in WAIT → mobo_stat=0, rdata_out=0; subsequent READ addr 7 returns the old value, not 0x1234.
- Change addr_in/wdata_in/cmd during BUSY (WRITE addr 9 → addr 10, data 0xFFFF) → only RAM[9] gets the original data. Holding cmd≠0 in DONE for 5 cycles keeps DONE=1 and starts no new access.
- WAIT_CYCLES=0 build: READ addr 0 → DONE after E0+2. Back-to-back WRITE/READ with one idle cycle between → both complete correctly.
